aer_event_sender: RTL and testbench

Downstream stage of the intensity sorter; it turns each sorted pixel index into one address-event for the SNN core. On every `FOUND_NEXT_INDEX` pulse it captures `NEXT_INDEX` and drives it onto the AER input bus with a 4-phase REQ/ACK handshake. `AERIN_CTRL_BUSY` back-pressures the sorter. The block also counts delivered events and flags handshake timeouts and overruns.

---
 rtl/aer_event_sender.sv | 156 +++++++++++++++
 tb/tb_aer_event_sender.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_event_sender.sv
// AER event sender: captures each sorted pixel index and delivers it as one address-event
// over a 4-phase REQ/ACK handshake, with delivered-event counting and timeout/overrun flags.
module aer_event_sender #(
  parameter int unsigned AER_BITS       = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_BITS       = 16
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic [AER_BITS-1:0] NEXT_INDEX,
  input  logic                FOUND_NEXT_INDEX,
  output logic                AERIN_CTRL_BUSY,
  output logic [AER_BITS-1:0] AERIN_ADDR,
  output logic                AERIN_REQ,
  input  logic                AERIN_ACK,
  input  logic                CLR_STATUS,
  output logic [CNT_BITS-1:0] EVENT_CNT,
  output logic                ERR_TIMEOUT,
  output logic                ERR_OVERRUN
);

  localparam bit                  TmoEn    = (TIMEOUT_CYCLES != 0);
  localparam int unsigned         TmoBits  = TmoEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TmoBits-1:0]  TmoLimit = TmoBits'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StWaitAckHi,
    StWaitAckLo
  } state_e;

  state_e              state_q, state_d;
  logic [AER_BITS-1:0] addr_q, addr_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic [TmoBits-1:0]  tmo_q, tmo_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                err_to_q, err_to_d;
  logic                err_ov_q, err_ov_d;
  logic                ack_meta_q, ack_s_q;
  logic [TmoBits-1:0]  tmo_inc;
  logic                tmo_hit;

  // ACK comes from another domain; two flops before the FSM looks at it.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= AERIN_ACK;
      ack_s_q    <= ack_meta_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    req_d    = req_q;
    busy_d   = busy_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    err_to_d = err_to_q;
    err_ov_d = err_ov_q;
    tmo_inc  = tmo_q + TmoBits'(1);
    // The edge that would bring the count to the limit is the abort edge.
    tmo_hit  = TmoEn && (tmo_inc == TmoLimit);

    unique case (state_q)
      StIdle: begin
        if (FOUND_NEXT_INDEX) begin
          addr_d  = NEXT_INDEX;
          busy_d  = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        req_d   = 1'b1;
        tmo_d   = '0;
        state_d = StWaitAckHi;
      end
      StWaitAckHi: begin
        if (ack_s_q) begin
          req_d   = 1'b0;
          tmo_d   = '0;
          state_d = StWaitAckLo;
        end else if (tmo_hit) begin
          req_d    = 1'b0;
          busy_d   = 1'b0;
          err_to_d = 1'b1;
          tmo_d    = '0;
          state_d  = StIdle;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      StWaitAckLo: begin
        if (!ack_s_q) begin
          busy_d  = 1'b0;
          cnt_d   = cnt_q + CNT_BITS'(1);
          state_d = StIdle;
        end else if (tmo_hit) begin
          req_d    = 1'b0;
          busy_d   = 1'b0;
          err_to_d = 1'b1;
          tmo_d    = '0;
          state_d  = StIdle;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      default: state_d = StIdle;
    endcase

    if (FOUND_NEXT_INDEX && (state_q != StIdle)) begin
      err_ov_d = 1'b1;
    end

    // Clear has priority over any same-cycle increment or error.
    if (CLR_STATUS) begin
      cnt_d    = '0;
      err_to_d = 1'b0;
      err_ov_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
    end
  end

  assign AERIN_CTRL_BUSY = busy_q;
  assign AERIN_ADDR      = addr_q;
  assign AERIN_REQ       = req_q;
  assign EVENT_CNT       = cnt_q;
  assign ERR_TIMEOUT     = err_to_q;
  assign ERR_OVERRUN     = err_ov_q;

endmodule

// File: tb/tb_aer_event_sender.sv
// Bench for aer_event_sender: randomized events against a transaction-level timing model,
// with an ACK responder whose delays drive the expected handshake latencies.
module tb_aer_event_sender;

  localparam int unsigned AerBits   = 10;
  localparam int unsigned TmoCycles = 8;
  localparam int unsigned CntBits   = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [AerBits-1:0] next_index;
  logic               found;
  logic               busy;
  logic [AerBits-1:0] aer_addr;
  logic               aer_req;
  logic               aer_ack;
  logic               clr_status;
  logic [CntBits-1:0] event_cnt;
  logic               err_timeout;
  logic               err_overrun;

  int n_chk  = 0;
  int n_fail = 0;

  int   exp_cnt = 0;
  logic exp_ov  = 1'b0;
  logic exp_to  = 1'b0;

  // Responder control: 0 normal, 1 never raise ACK, 2 never drop ACK.
  int dly_hi   = 0;
  int dly_lo   = 0;
  int ack_mode = 0;
  int ack_wait = 0;

  aer_event_sender #(
    .AER_BITS      (AerBits),
    .TIMEOUT_CYCLES(TmoCycles),
    .CNT_BITS      (CntBits)
  ) dut (
    .CLK             (clk),
    .RSTN            (rst_n),
    .NEXT_INDEX      (next_index),
    .FOUND_NEXT_INDEX(found),
    .AERIN_CTRL_BUSY (busy),
    .AERIN_ADDR      (aer_addr),
    .AERIN_REQ       (aer_req),
    .AERIN_ACK       (aer_ack),
    .CLR_STATUS      (clr_status),
    .EVENT_CNT       (event_cnt),
    .ERR_TIMEOUT     (err_timeout),
    .ERR_OVERRUN     (err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_clear();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    exp_cnt = 0;
    exp_ov  = 1'b0;
    exp_to  = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    chk_eq({tag, "_cnt"}, 32'(event_cnt), exp_cnt);
    chk_eq({tag, "_ovr"}, 32'(err_overrun), 32'(exp_ov));
    chk_eq({tag, "_tmo"}, 32'(err_timeout), 32'(exp_to));
  endtask

  // One complete event; ov_at/clr_at name the edge (counted from capture) on which an
  // overrun pulse or a status clear is presented, or -1 for none.
  task automatic send_event(input logic [AerBits-1:0] addr, input int dh, input int dl,
                            input int ov_at, input int clr_at);
    int req_fall  = -1;
    int busy_fall = -1;
    dly_hi     = dh;
    dly_lo     = dl;
    next_index = addr;
    found      = 1'b1;
    tick();
    found      = 1'b0;
    next_index = AerBits'($urandom);
    chk_eq("addr_capture", 32'(aer_addr), 32'(addr));
    chk_eq("busy_after_capture", 32'(busy), 1);
    chk_eq("req_during_setup", 32'(aer_req), 0);
    for (int i = 1; i <= 40; i++) begin
      if (i == ov_at) begin
        next_index = AerBits'($urandom);
        found      = 1'b1;
      end
      if (i == clr_at) clr_status = 1'b1;
      tick();
      found      = 1'b0;
      clr_status = 1'b0;
      if (i == 1) chk_eq("req_rise", 32'(aer_req), 1);
      if (req_fall < 0 && i > 1 && !aer_req) req_fall = i;
      if (!busy) begin
        busy_fall = i;
        break;
      end
    end
    if (ov_at > 0) exp_ov = 1'b1;
    if (clr_at > 0) begin
      exp_cnt = 0;
      exp_ov  = 1'b0;
      exp_to  = 1'b0;
    end else begin
      exp_cnt = (exp_cnt + 1) % (1 << CntBits);
    end
    chk_eq("req_fall_edge", req_fall, 4 + dh);
    chk_eq("busy_fall_edge", busy_fall, 7 + dh + dl);
    chk_eq("addr_held", 32'(aer_addr), 32'(addr));
    chk_status("event");
  endtask

  // ACK responder, acting 1 time unit after each edge.
  initial begin
    aer_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!aer_ack && aer_req && ack_mode != 1) begin
        if (ack_wait >= dly_hi) begin
          aer_ack  = 1'b1;
          ack_wait = 0;
        end else begin
          ack_wait++;
        end
      end else if (aer_ack && !aer_req && ack_mode != 2) begin
        if (ack_wait >= dly_lo) begin
          aer_ack  = 1'b0;
          ack_wait = 0;
        end else begin
          ack_wait++;
        end
      end else begin
        ack_wait = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AerBits-1:0] a;
    int dh, dl, ov;
    rst_n      = 1'b0;
    next_index = '0;
    found      = 1'b0;
    clr_status = 1'b0;
    tick();
    tick();
    chk_eq("rst_busy", 32'(busy), 0);
    chk_eq("rst_req", 32'(aer_req), 0);
    chk_eq("rst_addr", 32'(aer_addr), 0);
    chk_status("rst");
    rst_n = 1'b1;
    tick();

    // Single event, ACK answering a few cycles after REQ.
    send_event(10'h05A, 3, 3, -1, -1);

    // Back-to-back stream, next pulse on the cycle BUSY is seen low.
    send_event(10'h000, 0, 0, -1, -1);
    send_event(10'h0FF, 0, 0, -1, -1);
    send_event(10'h1FF, 0, 0, -1, -1);
    chk_eq("stream_cnt", 32'(event_cnt), 4);
    chk_eq("stream_no_overrun", 32'(err_overrun), 0);

    // Overrun while waiting for ACK high.
    send_event(10'h2B4, 2, 1, 2, -1);
    chk_eq("overrun_flag", 32'(err_overrun), 1);
    chk_eq("overrun_addr", 32'(aer_addr), 32'h2B4);
    chk_eq("overrun_cnt", 32'(event_cnt), 5);
    do_clear();
    chk_status("clear1");

    // Timeout waiting for ACK high.
    ack_mode   = 1;
    next_index = 10'h2A5;
    found      = 1'b1;
    tick();
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 8) chk_eq("tmo_hi_req_before", 32'(aer_req), 1);
    end
    tick();
    exp_to = 1'b1;
    chk_eq("tmo_hi_req", 32'(aer_req), 0);
    chk_eq("tmo_hi_busy", 32'(busy), 0);
    chk_status("tmo_hi");
    ack_mode = 0;
    do_clear();
    chk_status("tmo_hi_clear");

    // Timeout waiting for ACK low.
    ack_mode   = 2;
    dly_hi     = 0;
    dly_lo     = 0;
    next_index = 10'h11C;
    found      = 1'b1;
    tick();
    found = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 4) chk_eq("tmo_lo_req_fall", 32'(aer_req), 0);
      if (i == 11) chk_eq("tmo_lo_busy_before", 32'(busy), 1);
    end
    tick();
    exp_to = 1'b1;
    chk_eq("tmo_lo_busy", 32'(busy), 0);
    chk_status("tmo_lo");
    ack_mode = 0;
    for (int i = 0; i < 4; i++) tick();
    do_clear();

    // Reset asserted mid-handshake, with an overrun already flagged.
    send_event(10'h0C0, 0, 0, -1, -1);
    dly_hi     = 3;
    next_index = 10'h377;
    found      = 1'b1;
    tick();
    next_index = 10'h001;
    tick();
    found = 1'b0;
    chk_eq("pre_rst_req", 32'(aer_req), 1);
    chk_eq("pre_rst_ovr", 32'(err_overrun), 1);
    #3;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    exp_ov  = 1'b0;
    exp_to  = 1'b0;
    chk_eq("async_rst_req", 32'(aer_req), 0);
    chk_eq("async_rst_busy", 32'(busy), 0);
    chk_eq("async_rst_addr", 32'(aer_addr), 0);
    chk_status("async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send_event(10'h3C3, 1, 1, -1, -1);

    // Counter wrap: 17 events into a 4-bit counter.
    do_clear();
    for (int i = 0; i < 17; i++) send_event(AerBits'($urandom), 0, 0, -1, -1);
    chk_eq("cnt_wrap", 32'(event_cnt), 1);
    // Clear on the very edge that completes a handshake.
    send_event(10'h155, 0, 0, -1, 7);
    chk_eq("clr_wins", 32'(event_cnt), 0);

    // Randomized events with random ACK latencies and occasional overruns.
    for (int n = 0; n < 30; n++) begin
      a  = AerBits'($urandom);
      dh = int'($urandom_range(0, 3));
      dl = int'($urandom_range(0, 3));
      ov = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6 + dh + dl)) : -1;
      send_event(a, dh, dl, ov, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
